// File: rtl/ssd1306_spi_tx_if.sv
// Byte handshake between the microcode executor and the SSD1306 SPI transmitter.
// The executor is the master: it offers a byte plus a frame-end flag and
// fires a trigger; the transmitter answers with ready while it can accept.
interface ssd1306_spi_tx_if;
  logic       tx_trigger_in;
  logic [7:0] data_in;
  logic       last_byte_in;
  logic       ready_out;

  modport master (
    output tx_trigger_in,
    output data_in,
    output last_byte_in,
    input  ready_out
  );

  modport slave (
    input  tx_trigger_in,
    input  data_in,
    input  last_byte_in,
    output ready_out
  );
endinterface

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 master transmitter for the SSD1306 serial bus.
// Shifts one byte MSB-first per accepted trigger. Chip select opens on the
// first byte of a frame and stays low until a byte flagged as last has gone
// out, followed by a hold phase and a minimum deselect phase.
// Every non-idle state lasts exactly CLK_DIV clk_in cycles.
module ssd1306_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic            clk_in,
  input  logic            resetn_in,
  ssd1306_spi_tx_if.slave tx,
  output logic            spi_sclk_out,
  output logic            spi_mosi_out,
  output logic            spi_csn_out
);

  localparam int              PW      = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0]   PH_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CLK_LOW,
    CLK_HIGH,
    CS_HOLD,
    CS_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          last_q, last_d;
  logic          csn_q, csn_d;
  logic          sclk_q;
  logic          ready_q;
  logic          phase_end;

  // The shared phase counter expires on the last cycle of any busy state.
  assign phase_end = (state_q != IDLE) && (phase_q == PH_LAST);

  // Next-state, datapath and chip-select decisions.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    csn_d   = csn_q;

    if (state_q != IDLE)
      phase_d = phase_end ? '0 : phase_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (tx.tx_trigger_in) begin
          shreg_d = tx.data_in;
          last_d  = tx.last_byte_in;
          bit_d   = '0;
          phase_d = '0;
          // An open frame skips the setup phase and starts clocking at once.
          if (csn_q) begin
            csn_d   = 1'b0;
            state_d = CS_SETUP;
          end else begin
            state_d = CLK_LOW;
          end
        end
      end
      CS_SETUP: if (phase_end) state_d = CLK_LOW;
      CLK_LOW:  if (phase_end) state_d = CLK_HIGH;
      CLK_HIGH: begin
        if (phase_end) begin
          // Shifting here makes the next bit appear with the falling edge;
          // zero fill leaves MOSI low once the byte is done.
          shreg_d = {shreg_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = last_q ? CS_HOLD : IDLE;
          else
            state_d = CLK_LOW;
        end
      end
      CS_HOLD: begin
        if (phase_end) begin
          csn_d   = 1'b1;
          state_d = CS_HIGH;
        end
      end
      CS_HIGH:  if (phase_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and datapath registers; outputs are registered from the next state
  // so SCLK, CSn and ready never glitch on state decode.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      csn_q   <= csn_d;
      sclk_q  <= (state_d == CLK_HIGH);
      ready_q <= (state_d == IDLE);
    end
  end

  assign tx.ready_out = ready_q;
  assign spi_sclk_out = sclk_q;
  assign spi_mosi_out = shreg_q[7];
  assign spi_csn_out  = csn_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Bench for ssd1306_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Bytes are pushed to a per-instance queue when offered; a bus monitor
// rebuilds bytes from MOSI at SCLK rising edges and pops/compares them.
module tb_ssd1306_spi_tx;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ssd1306_spi_tx_if m0();
  ssd1306_spi_tx_if m1();
  logic sclk0, mosi0, csn0, sclk1, mosi1, csn1;

  ssd1306_spi_tx #(.CLK_DIV(2)) dut (
    .clk_in(clk), .resetn_in(resetn), .tx(m0),
    .spi_sclk_out(sclk0), .spi_mosi_out(mosi0), .spi_csn_out(csn0));

  ssd1306_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk_in(clk), .resetn_in(resetn), .tx(m1),
    .spi_sclk_out(sclk1), .spi_mosi_out(mosi1), .spi_csn_out(csn1));

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int bytes0 = 0;
  int bytes1 = 0;

  // Bus monitor / scoreboard for the CLK_DIV=2 instance.
  logic prev0 = 1'b0;
  int nb0 = 0;
  logic [7:0] sh0 = 8'h00;
  logic [7:0] e0;
  always @(negedge clk) begin
    if (!resetn || csn0) nb0 = 0;
    if (resetn && sclk0 && !prev0) begin
      checks++;
      if (csn0 !== 1'b0) begin failures++; $display("FAIL sb0_csn_at_edge: csn=%b required 0", csn0); end
      sh0 = {sh0[6:0], mosi0};
      nb0++;
      if (nb0 == 8) begin
        nb0 = 0;
        bytes0++;
        checks++;
        if (q0.size() == 0) begin
          failures++; $display("FAIL sb0_unexpected_byte: got %h, none required", sh0);
        end else begin
          e0 = q0.pop_front();
          if (sh0 !== e0) begin failures++; $display("FAIL sb0_byte: got %h required %h", sh0, e0); end
        end
      end
    end
    prev0 = sclk0;
  end

  // Bus monitor / scoreboard for the CLK_DIV=1 instance.
  logic prev1 = 1'b0;
  int nb1 = 0;
  logic [7:0] sh1 = 8'h00;
  logic [7:0] e1;
  always @(negedge clk) begin
    if (!resetn || csn1) nb1 = 0;
    if (resetn && sclk1 && !prev1) begin
      checks++;
      if (csn1 !== 1'b0) begin failures++; $display("FAIL sb1_csn_at_edge: csn=%b required 0", csn1); end
      sh1 = {sh1[6:0], mosi1};
      nb1++;
      if (nb1 == 8) begin
        nb1 = 0;
        bytes1++;
        checks++;
        if (q1.size() == 0) begin
          failures++; $display("FAIL sb1_unexpected_byte: got %h, none required", sh1);
        end else begin
          e1 = q1.pop_front();
          if (sh1 !== e1) begin failures++; $display("FAIL sb1_byte: got %h required %h", sh1, e1); end
        end
      end
    end
    prev1 = sclk1;
  end

  task automatic test_reset();
    resetn = 1'b0;
    m0.tx_trigger_in = 1'b0; m0.data_in = 8'h00; m0.last_byte_in = 1'b0;
    m1.tx_trigger_in = 1'b0; m1.data_in = 8'h00; m1.last_byte_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m0.ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready0: got %b want 1", m0.ready_out); end
    checks++; if (sclk0 !== 1'b0) begin failures++; $display("FAIL reset_sclk0: got %b want 0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin failures++; $display("FAIL reset_mosi0: got %b want 0", mosi0); end
    checks++; if (csn0 !== 1'b1) begin failures++; $display("FAIL reset_csn0: got %b want 1", csn0); end
    checks++; if (m1.ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready1: got %b want 1", m1.ready_out); end
    checks++; if (sclk1 !== 1'b0) begin failures++; $display("FAIL reset_sclk1: got %b want 0", sclk1); end
    checks++; if (mosi1 !== 1'b0) begin failures++; $display("FAIL reset_mosi1: got %b want 0", mosi1); end
    checks++; if (csn1 !== 1'b1) begin failures++; $display("FAIL reset_csn1: got %b want 1", csn1); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m0.ready_out !== 1'b1 || csn0 !== 1'b1) begin
      failures++; $display("FAIL reset_release: ready=%b csn=%b want 1 1", m0.ready_out, csn0); end
  endtask

  // New frame, 0xA5, last=1, CLK_DIV=2.
  task automatic test_single_byte();
    logic [7:0] pat;
    logic prev;
    int rise, b;
    pat = 8'hA5; prev = 1'b0; rise = 0; b = bytes0;
    @(negedge clk);
    checks++; if (m0.ready_out !== 1'b1) begin failures++; $display("FAIL single_pre_ready: got %b want 1", m0.ready_out); end
    m0.data_in = pat; m0.last_byte_in = 1'b1; m0.tx_trigger_in = 1'b1;
    q0.push_back(pat);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++; if (csn0 !== (j >= 37)) begin failures++; $display("FAIL single_csn@T+%0d: got %b want %b", j, csn0, (j >= 37)); end
      checks++; if (m0.ready_out !== (j >= 39)) begin failures++; $display("FAIL single_ready@T+%0d: got %b want %b", j, m0.ready_out, (j >= 39)); end
      if (sclk0 && !prev) begin
        rise++;
        checks++; if (j != 4 * rise + 1) begin failures++; $display("FAIL single_rise%0d_time: got T+%0d want T+%0d", rise, j, 4 * rise + 1); end
        if (rise <= 8) begin
          checks++; if (mosi0 !== pat[8 - rise]) begin failures++; $display("FAIL single_bit%0d: got %b want %b", rise - 1, mosi0, pat[8 - rise]); end
        end
      end
      if (j == 39) begin
        checks++; if (mosi0 !== 1'b0) begin failures++; $display("FAIL single_mosi_end: got %b want 0", mosi0); end
      end
      prev = sclk0;
      if (j == 1) m0.tx_trigger_in = 1'b0;
    end
    checks++; if (rise != 8) begin failures++; $display("FAIL single_rise_count: got %0d want 8", rise); end
    checks++; if (bytes0 != b + 1) begin failures++; $display("FAIL single_bytes: got %0d want %0d", bytes0 - b, 1); end
  endtask

  // 0x81 (last=0) then 0x3C (last=1) triggered on the first ready cycle.
  task automatic test_two_byte_frame();
    logic [15:0] pat;
    logic prev;
    int rise, b;
    pat = 16'h813C; prev = 1'b0; rise = 0; b = bytes0;
    @(negedge clk);
    m0.data_in = 8'h81; m0.last_byte_in = 1'b0; m0.tx_trigger_in = 1'b1;
    q0.push_back(8'h81);
    for (int j = 1; j <= 73; j++) begin
      @(negedge clk);
      checks++; if (csn0 !== (j >= 70)) begin failures++; $display("FAIL frame_csn@T+%0d: got %b want %b", j, csn0, (j >= 70)); end
      checks++; if (m0.ready_out !== (j == 35 || j >= 72)) begin
        failures++; $display("FAIL frame_ready@T+%0d: got %b want %b", j, m0.ready_out, (j == 35 || j >= 72)); end
      if (sclk0 && !prev) begin
        rise++;
        checks++; if (j != ((rise <= 8) ? 4 * rise + 1 : 4 * rise + 2)) begin
          failures++; $display("FAIL frame_rise%0d_time: got T+%0d want T+%0d", rise, j, (rise <= 8) ? 4 * rise + 1 : 4 * rise + 2); end
        if (rise <= 16) begin
          checks++; if (mosi0 !== pat[16 - rise]) begin failures++; $display("FAIL frame_bit%0d: got %b want %b", rise - 1, mosi0, pat[16 - rise]); end
        end
      end
      prev = sclk0;
      if (j == 1 || j == 36) m0.tx_trigger_in = 1'b0;
      if (j == 35) begin
        m0.data_in = 8'h3C; m0.last_byte_in = 1'b1; m0.tx_trigger_in = 1'b1;
        q0.push_back(8'h3C);
      end
    end
    checks++; if (rise != 16) begin failures++; $display("FAIL frame_rise_count: got %0d want 16", rise); end
    checks++; if (bytes0 != b + 2) begin failures++; $display("FAIL frame_bytes: got %0d want 2", bytes0 - b); end
  endtask

  // CLK_DIV=1, 0xFF, last=1: SCLK toggles every cycle.
  task automatic test_clk_div1();
    logic prev;
    logic exp_sclk;
    int rise, b;
    prev = 1'b0; rise = 0; b = bytes1;
    @(negedge clk);
    checks++; if (m1.ready_out !== 1'b1) begin failures++; $display("FAIL div1_pre_ready: got %b want 1", m1.ready_out); end
    m1.data_in = 8'hFF; m1.last_byte_in = 1'b1; m1.tx_trigger_in = 1'b1;
    q1.push_back(8'hFF);
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      exp_sclk = (j >= 3 && j <= 17 && (j % 2) == 1);
      checks++; if (sclk1 !== exp_sclk) begin failures++; $display("FAIL div1_sclk@T+%0d: got %b want %b", j, sclk1, exp_sclk); end
      checks++; if (csn1 !== (j >= 19)) begin failures++; $display("FAIL div1_csn@T+%0d: got %b want %b", j, csn1, (j >= 19)); end
      checks++; if (m1.ready_out !== (j >= 20)) begin failures++; $display("FAIL div1_ready@T+%0d: got %b want %b", j, m1.ready_out, (j >= 20)); end
      if (sclk1 && !prev) rise++;
      prev = sclk1;
      if (j == 1) m1.tx_trigger_in = 1'b0;
    end
    checks++; if (rise != 8) begin failures++; $display("FAIL div1_rise_count: got %0d want 8", rise); end
    checks++; if (bytes1 != b + 1) begin failures++; $display("FAIL div1_bytes: got %0d want 1", bytes1 - b); end
  endtask

  // Triggers at T+3 and T+10 with other data/flag must be ignored.
  task automatic test_ignore_busy();
    int b;
    b = bytes0;
    @(negedge clk);
    m0.data_in = 8'h5A; m0.last_byte_in = 1'b1; m0.tx_trigger_in = 1'b1;
    q0.push_back(8'h5A);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++; if (csn0 !== (j >= 37)) begin failures++; $display("FAIL ignore_csn@T+%0d: got %b want %b", j, csn0, (j >= 37)); end
      checks++; if (m0.ready_out !== (j >= 39)) begin failures++; $display("FAIL ignore_ready@T+%0d: got %b want %b", j, m0.ready_out, (j >= 39)); end
      if (j == 3 || j == 10) begin
        m0.data_in = 8'hFF; m0.last_byte_in = 1'b0; m0.tx_trigger_in = 1'b1;
      end else begin
        m0.tx_trigger_in = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (bytes0 != b + 1) begin failures++; $display("FAIL ignore_bytes: got %0d want 1", bytes0 - b); end
    checks++; if (csn0 !== 1'b1) begin failures++; $display("FAIL ignore_csn_idle: got %b want 1", csn0); end
  endtask

  // Reset during bit 4 aborts; next trigger opens a fresh frame with setup.
  task automatic test_reset_mid();
    logic prev;
    int rise;
    @(negedge clk);
    m0.data_in = 8'h0F; m0.last_byte_in = 1'b1; m0.tx_trigger_in = 1'b1;
    q0.push_back(8'h0F);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) m0.tx_trigger_in = 1'b0;
    end
    checks++; if (mosi0 !== 1'b1 || m0.ready_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_pre: mosi=%b ready=%b want 1 0", mosi0, m0.ready_out); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (csn0 !== 1'b1) begin failures++; $display("FAIL rstmid_csn: got %b want 1", csn0); end
    checks++; if (sclk0 !== 1'b0) begin failures++; $display("FAIL rstmid_sclk: got %b want 0", sclk0); end
    checks++; if (m0.ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", m0.ready_out); end
    checks++; if (mosi0 !== 1'b0) begin failures++; $display("FAIL rstmid_mosi: got %b want 0", mosi0); end
    q0.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    m0.data_in = 8'hC3; m0.last_byte_in = 1'b1; m0.tx_trigger_in = 1'b1;
    q0.push_back(8'hC3);
    prev = 1'b0; rise = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++; if (csn0 !== (j >= 37)) begin failures++; $display("FAIL rstmid_new_csn@T+%0d: got %b want %b", j, csn0, (j >= 37)); end
      if (sclk0 && !prev) begin
        rise++;
        checks++; if (j != 4 * rise + 1) begin failures++; $display("FAIL rstmid_rise%0d_time: got T+%0d want T+%0d", rise, j, 4 * rise + 1); end
      end
      prev = sclk0;
      if (j == 1) m0.tx_trigger_in = 1'b0;
    end
    checks++; if (m0.ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_new_ready: got %b want 1", m0.ready_out); end
  endtask

  // Trigger held high for three bytes (last=0,0,1).
  task automatic test_back_to_back();
    int acc, last_acc, b;
    logic pend, done;
    b = bytes0;
    @(negedge clk);
    checks++; if (m0.ready_out !== 1'b1) begin failures++; $display("FAIL b2b_pre_ready: got %b want 1", m0.ready_out); end
    m0.data_in = 8'h11; m0.last_byte_in = 1'b0; m0.tx_trigger_in = 1'b1;
    q0.push_back(8'h11);
    acc = 1; last_acc = 0; pend = 1'b1; done = 1'b0;
    for (int j = 1; j <= 200 && !done; j++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        checks++; if (m0.ready_out !== 1'b0) begin failures++; $display("FAIL b2b_ready_pulse@%0d: got %b want 0", j, m0.ready_out); end
        if (acc == 1) begin
          m0.data_in = 8'h22; m0.last_byte_in = 1'b0; q0.push_back(8'h22);
        end else if (acc == 2) begin
          m0.data_in = 8'h33; m0.last_byte_in = 1'b1; q0.push_back(8'h33);
        end else begin
          m0.tx_trigger_in = 1'b0;
        end
      end else if (m0.ready_out === 1'b1) begin
        if (m0.tx_trigger_in) begin
          acc++;
          pend = 1'b1;
          checks++; if (j - last_acc != ((acc == 2) ? 35 : 33)) begin
            failures++; $display("FAIL b2b_gap%0d: got %0d want %0d", acc, j - last_acc, (acc == 2) ? 35 : 33); end
          last_acc = j;
        end else begin
          done = 1'b1;
        end
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL b2b_timeout: ready not seen, got 0 want 1"); end
    checks++; if (acc != 3) begin failures++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    repeat (4) @(negedge clk);
    checks++; if (bytes0 != b + 3) begin failures++; $display("FAIL b2b_bytes: got %0d want 3", bytes0 - b); end
  endtask

  task automatic test_drain();
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL drain_q0: got %0d pending want 0", q0.size()); end
    checks++; if (q1.size() != 0) begin failures++; $display("FAIL drain_q1: got %0d pending want 0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte_frame();
    test_clk_div1();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, got timeout want completion");
    $fatal(1);
  end
endmodule
